mul_div_unit: RTL and testbench

//   Parametrised multi-cycle multiply/divide unit.
//   - Successor to the single-cycle ALU for the pipelined CPU; sits in EX beside the ALU.
//   - Owns the HI/LO registers; signed/unsigned MULT and DIV, plus MTHI/MTLO writes.
//   - Holds busy for a fixed programmable latency; the hazard unit stalls on busy/start.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_if.sv | 15 +
 rtl/mdu_arith.sv | 41 ++++
 rtl/mul_div_unit.sv | 88 ++++++++
 tb/tb_mul_div_unit.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit; the decoder and hazard unit
// import the same op and state constants.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic isSignedOp(logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic isDivOp(logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, srcA, srcB, input busy, hi, lo);
  modport slave  (input start, op, srcA, srcB, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned multiply and divide producing the full
// {hi,lo} result and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   srcA_i,
  input  logic [WIDTH-1:0]   srcB_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               divByZero_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic               signedOp;
  logic               aNeg, bNeg;
  logic [2*WIDTH-1:0] aExt, bExt, prod;
  logic [WIDTH-1:0]   aMag, bMag, divisor, qMag, rMag, quot, rem;

  // Divide on magnitudes so MIN_INT / -1 wraps naturally to MIN_INT, remainder 0.
  always_comb begin
    signedOp    = isSignedOp(op_i);
    aNeg        = signedOp & srcA_i[WIDTH-1];
    bNeg        = signedOp & srcB_i[WIDTH-1];
    aExt        = {{WIDTH{aNeg}}, srcA_i};
    bExt        = {{WIDTH{bNeg}}, srcB_i};
    prod        = aExt * bExt;
    aMag        = aNeg ? (~srcA_i + ONE) : srcA_i;
    bMag        = bNeg ? (~srcB_i + ONE) : srcB_i;
    divisor     = (srcB_i == '0) ? ONE : bMag;
    qMag        = aMag / divisor;
    rMag        = aMag % divisor;
    quot        = (aNeg ^ bNeg) ? (~qMag + ONE) : qMag;
    rem         = aNeg ? (~rMag + ONE) : rMag;
    divByZero_o = isDivOp(op_i) && (srcB_i == '0);
    result_o    = isDivOp(op_i) ? {rem, quot} : prod;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO; busy is held for a fixed latency
// so the hazard unit can stall dependent instructions.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mdu_state_e         stateQ;
  logic [CNT_W-1:0]   cntQ;
  logic               busyQ;
  logic [WIDTH-1:0]   hiQ, loQ;
  logic [2*WIDTH-1:0] pendQ;
  logic               pendZeroQ;
  logic [2*WIDTH-1:0] pendingD;
  logic               divByZeroD;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i        (bus.op),
    .srcA_i      (bus.srcA),
    .srcB_i      (bus.srcB),
    .result_o    (pendingD),
    .divByZero_o (divByZeroD)
  );

  // The result is computed at accept time; the counter only models latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= S_IDLE;
      cntQ      <= '0;
      busyQ     <= 1'b0;
      hiQ       <= '0;
      loQ       <= '0;
      pendQ     <= '0;
      pendZeroQ <= 1'b0;
    end else begin
      case (stateQ)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                pendQ     <= pendingD;
                pendZeroQ <= divByZeroD;
                cntQ      <= isDivOp(bus.op) ? DIV_CNT : MUL_CNT;
                busyQ     <= 1'b1;
                stateQ    <= S_BUSY;
              end
              MDU_MTHI: hiQ <= bus.srcA;
              MDU_MTLO: loQ <= bus.srcA;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cntQ == CNT_ONE) begin
            if (!pendZeroQ) begin
              hiQ <= pendQ[2*WIDTH-1:WIDTH];
              loQ <= pendQ[WIDTH-1:0];
            end
            cntQ   <= '0;
            busyQ  <= 1'b0;
            stateQ <= S_IDLE;
          end else begin
            cntQ <= cntQ - CNT_ONE;
          end
        end
        default: stateQ <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busyQ;
  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench: directed cases plus random traffic compared every cycle
// against a plain-arithmetic model of HI/LO and busy.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W    = 32;
  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  logic [31:0] mHi, mLo, mPendHi, mPendLo;
  logic        mPendWrite;
  int          mLeft;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a launched op lands its result after its latency, unless aborted.
  task automatic modelEdge(bit r, bit st, logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, rr;
    logic [63:0] p;
    if (r) begin
      mHi = '0; mLo = '0; mLeft = 0;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0 && mPendWrite) begin
        mHi = mPendHi; mLo = mPendLo;
      end
    end else if (st) begin
      case (o)
        3'd0: begin
          p = longint'($signed(a)) * longint'($signed(b));
          {mPendHi, mPendLo} = p; mPendWrite = 1'b1; mLeft = MULN;
        end
        3'd1: begin
          p = {32'b0, a} * {32'b0, b};
          {mPendHi, mPendLo} = p; mPendWrite = 1'b1; mLeft = MULN;
        end
        3'd2: begin
          mLeft = DIVN; mPendWrite = (b != 0);
          if (b != 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; rr = sa % sb;
            mPendLo = q[31:0]; mPendHi = rr[31:0];
          end
        end
        3'd3: begin
          mLeft = DIVN; mPendWrite = (b != 0);
          if (b != 0) begin
            mPendLo = a / b; mPendHi = a % b;
          end
        end
        3'd4: mHi = a;
        3'd5: mLo = a;
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(bit r, bit st, logic [2:0] o, logic [31:0] a, logic [31:0] b);
    reset = r; bus.start = st; bus.op = o; bus.srcA = a; bus.srcB = b;
    @(posedge clk);
    modelEdge(r, st, o, a, b);
    compareOn = 1'b1;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd7, $urandom, $urandom);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("busy", 32'(bus.busy), 32'(mLeft > 0));
      checkOutput("hi", bus.hi, mHi);
      checkOutput("lo", bus.lo, mLo);
    end
  end

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.op = 3'd7; bus.srcA = '0; bus.srcB = '0;
    applyStimulus(1'b1, 1'b0, 3'd7, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'd7, 32'd0, 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);

    applyStimulus(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_busy_first", 32'(bus.busy), 32'd1);
    idle(4);
    checkOutput("mult_busy_last", 32'(bus.busy), 32'd1);
    idle(1);
    checkOutput("mult_busy_done", 32'(bus.busy), 32'd0);
    checkOutput("mult_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", bus.lo, 32'hFFFF_FFEB);
    checkOutput("model_mult_lo", mLo, 32'hFFFF_FFEB);

    applyStimulus(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    checkOutput("multu_hi", bus.hi, 32'd1);
    checkOutput("multu_lo", bus.lo, 32'hFFFF_FFFE);

    applyStimulus(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    idle(9);
    checkOutput("div_busy_last", 32'(bus.busy), 32'd1);
    idle(1);
    checkOutput("div_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", bus.hi, 32'hFFFF_FFFF);
    checkOutput("model_div_hi", mHi, 32'hFFFF_FFFF);

    applyStimulus(1'b0, 1'b1, 3'd3, 32'd7, 32'd0);
    idle(10);
    checkOutput("divz_lo", bus.lo, 32'hFFFF_FFFD);
    checkOutput("divz_hi", bus.hi, 32'hFFFF_FFFF);

    applyStimulus(1'b0, 1'b1, 3'd4, 32'h1234, 32'd0);
    checkOutput("mthi_busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd5, 32'h5678, 32'd0);
    checkOutput("mt_hi", bus.hi, 32'h1234);
    checkOutput("mt_lo", bus.lo, 32'h5678);

    applyStimulus(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
    idle(1);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'd100, 32'd7);
    idle(3);
    checkOutput("ignored_busy", 32'(bus.busy), 32'd0);
    checkOutput("ignored_hi", bus.hi, 32'd0);
    checkOutput("ignored_lo", bus.lo, 32'd12);

    applyStimulus(1'b0, 1'b1, 3'd2, 32'd100, 32'd7);
    idle(2);
    applyStimulus(1'b1, 1'b0, 3'd7, 32'd0, 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_hi", bus.hi, 32'd0);
    idle(12);
    checkOutput("abort_late_lo", bus.lo, 32'd0);

    applyStimulus(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    checkOutput("ovf_lo", bus.lo, 32'h8000_0000);
    checkOutput("ovf_hi", bus.hi, 32'd0);

    applyStimulus(1'b0, 1'b1, 3'd0, 32'd2, 32'd3);
    idle(5);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'd5, 32'd5);
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    idle(5);
    checkOutput("b2b_lo", bus.lo, 32'd25);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                    3'($urandom_range(0, 7)), pickOperand(), pickOperand());
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
